// File: rtl/shift_issue_stage.sv
// Two-stage issue/retire wrapper around the external ALU shifters.
// Stage A registers the shifter operands; stage B captures the selected result.
module shift_issue_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_data,
  input  logic [31:0]      in_amt_reg,
  input  logic [4:0]       in_shamt,
  input  logic             in_use_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      sh_indata,
  output logic [4:0]       sh_shift,
  input  logic [31:0]      sll_out,
  input  logic [31:0]      srl_out,
  input  logic [31:0]      sra_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_err
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  logic             a_valid_q, a_valid_d;
  op_e              a_op_q, a_op_d;
  logic [31:0]      a_data_q, a_data_d;
  logic [4:0]       a_amt_q, a_amt_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;

  logic             b_valid_q, b_valid_d;
  logic [31:0]      b_data_q, b_data_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;
  logic             b_zero_q, b_zero_d;
  logic             b_neg_q, b_neg_d;
  logic             b_err_q, b_err_d;

  logic        a_adv;
  logic        accept;
  logic [4:0]  amt_sel;
  logic [31:0] res;
  logic        res_err;

  // Only the low five amount bits reach the shifters.
  logic unused_amt_hi;
  assign unused_amt_hi = ^in_amt_reg[31:5];

  assign a_adv    = a_valid_q & (~b_valid_q | out_ready);
  assign in_ready = ~a_valid_q | a_adv;
  assign accept   = in_valid & in_ready;
  assign amt_sel  = in_use_imm ? in_shamt : in_amt_reg[4:0];

  always_comb begin
    res     = a_data_q;
    res_err = 1'b0;
    unique case (1'b1)
      (a_op_q == OP_SLL): res = sll_out;
      (a_op_q == OP_SRL): res = srl_out;
      (a_op_q == OP_SRA): res = sra_out;
      (a_op_q == OP_RSV): res_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_op_d    = a_op_q;
    a_data_d  = a_data_q;
    a_amt_d   = a_amt_q;
    a_tag_d   = a_tag_q;
    if (accept) begin
      a_valid_d = 1'b1;
      a_op_d    = op_e'(in_op);
      a_data_d  = in_data;
      a_amt_d   = amt_sel;
      a_tag_d   = in_tag;
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end
  end

  always_comb begin
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_tag_d   = b_tag_q;
    b_zero_d  = b_zero_q;
    b_neg_d   = b_neg_q;
    b_err_d   = b_err_q;
    if (a_adv) begin
      b_valid_d = 1'b1;
      b_data_d  = res;
      b_tag_d   = a_tag_q;
      b_zero_d  = (res == 32'd0);
      b_neg_d   = res[31];
      b_err_d   = res_err;
    end else if (b_valid_q && out_ready) begin
      b_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_op_q    <= OP_SLL;
      a_data_q  <= '0;
      a_amt_q   <= '0;
      a_tag_q   <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_tag_q   <= '0;
      b_zero_q  <= 1'b0;
      b_neg_q   <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_op_q    <= a_op_d;
      a_data_q  <= a_data_d;
      a_amt_q   <= a_amt_d;
      a_tag_q   <= a_tag_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_tag_q   <= b_tag_d;
      b_zero_q  <= b_zero_d;
      b_neg_q   <= b_neg_d;
      b_err_q   <= b_err_d;
    end
  end

  assign sh_indata = a_data_q;
  assign sh_shift  = a_amt_q;
  assign out_valid = b_valid_q;
  assign out_data  = b_data_q;
  assign out_tag   = b_tag_q;
  assign out_zero  = b_zero_q;
  assign out_neg   = b_neg_q;
  assign out_err   = b_err_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage with behavioural shifters.
// Table vectors plus hand sequences for streaming, stall and reset.
module tb_shift_issue_stage;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_data;
  logic [31:0]      in_amt_reg;
  logic [4:0]       in_shamt;
  logic             in_use_imm;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      sh_indata;
  logic [4:0]       sh_shift;
  logic [31:0]      sll_out;
  logic [31:0]      srl_out;
  logic [31:0]      sra_out;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_neg;
  logic             out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sll_out = sh_indata << sh_shift;
  assign srl_out = sh_indata >> sh_shift;
  assign sra_out = $unsigned($signed(sh_indata) >>> sh_shift);

  shift_issue_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data),
    .in_amt_reg(in_amt_reg), .in_shamt(in_shamt),
    .in_use_imm(in_use_imm), .in_tag(in_tag),
    .sh_indata(sh_indata), .sh_shift(sh_shift),
    .sll_out(sll_out), .srl_out(srl_out), .sra_out(sra_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_zero(out_zero), .out_neg(out_neg), .out_err(out_err)
  );

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      data;
    logic [31:0]      amt_reg;
    logic [4:0]       shamt;
    logic             use_imm;
    logic [TAG_W-1:0] tag;
    logic [4:0]       exp_amt;
    logic [31:0]      exp_data;
    logic             exp_zero;
    logic             exp_neg;
    logic             exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] d,
                       input logic [31:0] ar, input logic [4:0] sa,
                       input logic ui, input logic [TAG_W-1:0] t);
    in_valid   = 1'b1;
    in_op      = op;
    in_data    = d;
    in_amt_reg = ar;
    in_shamt   = sa;
    in_use_imm = ui;
    in_tag     = t;
  endtask

  task automatic chk_idle_zero(input string pfx);
    chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({pfx, "_out_data"}, out_data, 32'd0);
    chk({pfx, "_out_tag"}, 32'(out_tag), 32'd0);
    chk({pfx, "_out_flags"}, {29'd0, out_err, out_zero, out_neg}, 32'd0);
    chk({pfx, "_sh_indata"}, sh_indata, 32'd0);
    chk({pfx, "_sh_shift"}, 32'(sh_shift), 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'b10, 32'h80000010, 32'd9, 5'd4, 1'b1, 4'd3,
                5'd4, 32'hF8000001, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'b00, 32'h00000001, 32'd33, 5'd7, 1'b0, 4'd1,
                5'd1, 32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 32'h80000000, 32'd2, 5'd31, 1'b1, 4'd2,
                5'd31, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 32'h12345678, 32'd4, 5'd4, 1'b1, 4'd4,
                5'd4, 32'h12345678, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{2'b01, 32'h0000000F, 32'd0, 5'd4, 1'b1, 4'd5,
                5'd4, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2'b00, 32'hDEADBEEF, 32'd0, 5'd3, 1'b0, 4'd6,
                5'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'b10, 32'h7FFFFFFF, 32'd1, 5'd31, 1'b1, 4'd7,
                5'd31, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd2, 1'b0, 4'd8,
                5'd31, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{2'b00, 32'h00000001, 32'd3, 5'd31, 1'b1, 4'd9,
                5'd31, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{2'b01, 32'hFFFFFFFF, 32'd32, 5'd5, 1'b0, 4'hF,
                5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(2'b00, 32'd0, 32'd0, 5'd0, 1'b0, '0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].op, vecs[i].data, vecs[i].amt_reg, vecs[i].shamt,
            vecs[i].use_imm, vecs[i].tag);
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_sh_indata", i), sh_indata, vecs[i].data);
      chk($sformatf("v%0d_sh_shift", i), 32'(sh_shift),
          32'(vecs[i].exp_amt));
      chk($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("v%0d_out_tag", i), 32'(out_tag), 32'(vecs[i].tag));
      chk($sformatf("v%0d_flags", i),
          {29'd0, out_err, out_zero, out_neg},
          {29'd0, vecs[i].exp_err, vecs[i].exp_zero, vecs[i].exp_neg});
    end
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Back-to-back stream with the consumer always ready.
    drive(2'b00, 32'h1, 32'd33, 5'd0, 1'b0, 4'hA);
    chk("b2b_rdy0", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 drive(2'b01, 32'h80000000, 32'd0, 5'd31, 1'b1, 4'hB);
    @(negedge clk);
    chk("b2b_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_v1", 32'(out_valid), 32'd1);
    chk("b2b_d1", out_data, 32'h2);
    chk("b2b_t1", 32'(out_tag), 32'hA);
    @(negedge clk);
    chk("b2b_v2", 32'(out_valid), 32'd1);
    chk("b2b_d2", out_data, 32'h1);
    chk("b2b_t2", 32'(out_tag), 32'hB);
    @(negedge clk);
    chk("b2b_end", 32'(out_valid), 32'd0);

    // Three requests against a stalled consumer.
    out_ready = 1'b0;
    drive(2'b00, 32'h11, 32'd0, 5'd1, 1'b1, 4'd1);
    chk("st_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 drive(2'b00, 32'h22, 32'd0, 5'd1, 1'b1, 4'd2);
    @(negedge clk);
    chk("st_rdy2", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 drive(2'b00, 32'h33, 32'd0, 5'd1, 1'b1, 4'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("st_full_rdy%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("st_hold_v%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("st_hold_d%0d", k), out_data, 32'h22);
      chk($sformatf("st_hold_t%0d", k), 32'(out_tag), 32'd1);
      chk($sformatf("st_hold_sh%0d", k), sh_indata, 32'h22);
    end
    out_ready = 1'b1;
    #1 chk("st_release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("st_r2_d", out_data, 32'h44);
    chk("st_r2_t", 32'(out_tag), 32'd2);
    @(negedge clk);
    chk("st_r3_v", 32'(out_valid), 32'd1);
    chk("st_r3_d", out_data, 32'h66);
    chk("st_r3_t", 32'(out_tag), 32'd3);
    @(negedge clk);
    chk("st_end", 32'(out_valid), 32'd0);

    // Reset while both stages are full.
    out_ready = 1'b0;
    drive(2'b10, 32'h80000000, 32'd0, 5'd1, 1'b1, 4'd5);
    @(posedge clk);
    #1 drive(2'b11, 32'hCAFEF00D, 32'd0, 5'd1, 1'b1, 4'd6);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rm_full_rdy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_idle_zero("rm");
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rm_no_stale%0d", k), 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Two-stage pipelined issue/retire wrapper around the ALU's combinational 32-bit shifters (logical-left, logical-right, arithmetic-right). Accepts shift requests from the decode stage over a valid/ready handshake and selects the shift amount (register or immediate). It registers the operands that drive the shared shifter inputs, then captures the op-selected shifter result with zero/negative flags for the ALU result bus. Throughput is one request per cycle; latency is 2 cycles; backpressure is fully supported.

## Interface
- TAG_W, 4, width of the request tag carried unchanged from request to result

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept request this cycle
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
- in_data  in  32  value to shift
- in_amt_reg  in  32  register-sourced amount; only bits [4:0] used
- in_shamt  in  5  immediate amount
- in_use_imm  in  1  1: amount = in_shamt; 0: amount = in_amt_reg[4:0]
- in_tag  in  TAG_W  request tag
- sh_indata  out  32  operand to all three shifters (registered)
- sh_shift  out  5  amount to all three shifters (registered)
- sll_out  in  32  logical-left shifter result
- srl_out  in  32  logical-right shifter result
- sra_out  in  32  arithmetic-right shifter result
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  32  shift result
- out_tag  out  TAG_W  tag of result
- out_zero  out  1  out_data == 0
- out_neg  out  1  out_data[31]
- out_err  out  1  request used reserved op 11

## Operation
- Stage A (operand register): a_valid, a_op, a_data, a_amt, a_tag. sh_indata = a_data, sh_shift = a_amt, driven directly from the registers.
- Stage B (result register): b_valid, b_data, b_tag, b_zero, b_neg, b_err, driving out_* directly.
- a_adv = a_valid & (~b_valid | out_ready).
- in_ready = ~a_valid | a_adv (combinational; no dependence on in_valid).
- Accept: in_valid & in_ready. Load A with in_op, in_data, selected amount, in_tag; set a_valid. If no accept and a_adv, clear a_valid.
- On a_adv, B loads the result selected by a_op:
  - 00: sll_out
  - 01: srl_out
  - 10: sra_out
  - 11: a_data unshifted, with b_err = 1
  - zero/neg flags are computed from the selected value.
- B retire: out_valid & out_ready with no a_adv clears b_valid. Simultaneous retire and a_adv keeps b_valid = 1 and loads the new result.
- Amount wrap: in_amt_reg bits [31:5] are ignored, e.g. 33 shifts by 1. A shift of 0 passes the data through for all ops.
- When out_ready is low, out_* hold stable while out_valid is high, and A holds.
- With both stages full and stalled, in_ready = 0.

## Timing
- Reset: all of the following are 0 on the first edge with rst = 1.
  - a_valid, b_valid, out_valid, out_err, out_zero, out_neg
  - out_data, out_tag, sh_indata, sh_shift
  - in_ready reads 1 in the cycle after reset deasserts.
- Reset mid-operation drops all in-flight requests; no out_valid pulse follows.
- Latency: a request accepted at edge N drives sh_* after edge N, and out_valid is high after edge N+1 if B was free or draining.
- Sustained rate is 1 result/cycle with out_ready held high.
- A stall of k cycles on out_ready delays all queued results by exactly k cycles, with no loss or duplication.
- The shifter path from sh_* to sll/srl/sra_out must complete within one clk period; there are no multicycle paths.

## Test plan
- Reset, then SRA with in_data = 0x80000010, imm amount 4, tag 3 -> out_valid 2 cycles after acceptance with out_data = 0xF8000001, out_neg = 1, out_zero = 0, out_tag = 3.
- Back-to-back SLL 0x00000001 by reg 33, then SRL 0x80000000 by imm 31, out_ready = 1 -> consecutive results 0x00000002, then 0x00000001, with in_ready constantly 1.
- Three requests issued while out_ready = 0 -> first two are accepted and in_ready drops. After out_ready rises for 3 cycles, results emerge in order with tags intact and out_data stable throughout the stall.
- Reserved op 11 on 0x12345678 -> out_data = 0x12345678, out_err = 1. Following SRL 0x0000000F by 4 -> out_data = 0, out_zero = 1, out_err = 0.
- Assert rst for 1 cycle with both stages full -> all outputs are 0 next cycle, no stale result ever appears, and in_ready = 1.
